// File: rtl/bit_sparsity_pkg.sv
// rtl/bit_sparsity_pkg.sv - shared widths, state enum and place type for the bit-serial scheduler
package bit_sparsity_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_PLACE_WIDTH = $clog2(DEFAULT_DATA_WIDTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } sched_state_e;

  typedef logic [DEFAULT_PLACE_WIDTH-1:0] place_t;

endpackage

// File: rtl/lane_msb_encoder.sv
// rtl/lane_msb_encoder.sv - highest-set-bit place, nonzero and popcount<=1 flags for one lane residual
module lane_msb_encoder #(
  parameter  int DATA_WIDTH  = 8,
  localparam int PLACE_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]  residual,
  output logic [PLACE_WIDTH-1:0] place,
  output logic                   nonzero,
  output logic                   single
);

  always_comb begin
    place = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (residual[i]) place = PLACE_WIDTH'(i);
    end
  end

  assign nonzero = |residual;
  // x & (x-1) strips the lowest set bit; zero result means at most one bit was set
  assign single  = ~|(residual & (residual - DATA_WIDTH'(1)));

endmodule

// File: rtl/bit_serial_lane_scheduler.sv
// rtl/bit_serial_lane_scheduler.sv - group-synchronised MSB-first bit-serial lane sequencer
module bit_serial_lane_scheduler
  import bit_sparsity_pkg::*;
#(
  parameter  int NUM_LANES   = 4,
  parameter  int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  localparam int PLACE_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                             CLK,
  input  logic                             RSTN,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]  in_values,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_LANES*PLACE_WIDTH-1:0] out_places,
  output logic [NUM_LANES-1:0]             out_mask,
  output logic                             out_last,
  output logic [PLACE_WIDTH:0]             out_beat,
  output logic                             busy
);

  sched_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] residual_q [NUM_LANES];
  logic [DATA_WIDTH-1:0] residual_d [NUM_LANES];
  logic [PLACE_WIDTH:0]  beat_q, beat_d;

  logic [PLACE_WIDTH-1:0] lane_place [NUM_LANES];
  logic [NUM_LANES-1:0]   lane_nonzero;
  logic [NUM_LANES-1:0]   lane_single;

  logic run, all_single, beat_acc, last_acc, load;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_msb_encoder #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
      .residual (residual_q[g]),
      .place    (lane_place[g]),
      .nonzero  (lane_nonzero[g]),
      .single   (lane_single[g])
    );
  end

  assign run        = (state_q == S_RUN);
  assign all_single = &lane_single;
  assign beat_acc   = run && out_ready;
  assign last_acc   = beat_acc && all_single;
  // A group may be taken on the final beat of the previous one, so there is no bubble
  assign in_ready   = RSTN && (!run || last_acc);
  assign load       = in_valid && in_ready;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load) state_d = S_RUN;
      S_RUN:   if (last_acc && !load) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid  = run;
    busy       = run;
    out_last   = run && all_single;
    out_mask   = run ? lane_nonzero : '0;
    out_beat   = beat_q;
    out_places = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (run) out_places[i*PLACE_WIDTH +: PLACE_WIDTH] = lane_place[i];
    end
  end

  always_comb begin
    logic [DATA_WIDTH-1:0] clr;
    beat_d = beat_q;
    clr    = '0;
    for (int i = 0; i < NUM_LANES; i++) residual_d[i] = residual_q[i];
    if (load) begin
      for (int i = 0; i < NUM_LANES; i++) residual_d[i] = in_values[i*DATA_WIDTH +: DATA_WIDTH];
      beat_d = '0;
    end else if (beat_acc) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        clr                = '0;
        clr[lane_place[i]] = lane_nonzero[i];
        residual_d[i]      = residual_q[i] & ~clr;
      end
      // Clearing on the last beat keeps out_beat within 0..DATA_WIDTH-1 while idle
      beat_d = all_single ? '0 : beat_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NUM_LANES; i++) residual_q[i] <= '0;
      beat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) residual_q[i] <= residual_d[i];
      beat_q <= beat_d;
    end
  end

endmodule

// File: tb/tb_bit_serial_lane_scheduler.sv
// tb/tb_bit_serial_lane_scheduler.sv - directed self-checking bench for bit_serial_lane_scheduler
module tb_bit_serial_lane_scheduler;
  import bit_sparsity_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_values;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_places;
  logic [3:0]  out_mask;
  logic        out_last;
  logic [3:0]  out_beat;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  bit_serial_lane_scheduler #(.NUM_LANES(4), .DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_values  (in_values),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_places (out_places),
    .out_mask   (out_mask),
    .out_last   (out_last),
    .out_beat   (out_beat),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pl(input place_t a3, input place_t a2, input place_t a1, input place_t a0);
    return {a3, a2, a1, a0};
  endfunction

  // Offer a group from IDLE; returns at the negedge where its first beat is visible
  task automatic send_group(input logic [31:0] v);
    int n;
    in_valid  = 1'b1;
    in_values = v;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(negedge CLK);
    in_valid  = 1'b0;
    in_values = 32'hDEAD_BEEF;
  endtask

  task automatic check_beat(input string tag, input logic [3:0] mask, input logic [11:0] places,
                            input logic last, input logic [3:0] beat);
    check({tag, "_valid"},  {31'd0, out_valid}, 32'd1);
    check({tag, "_busy"},   {31'd0, busy},      32'd1);
    check({tag, "_mask"},   {28'd0, out_mask},  {28'd0, mask});
    check({tag, "_places"}, {20'd0, out_places}, {20'd0, places});
    check({tag, "_last"},   {31'd0, out_last},  {31'd0, last});
    check({tag, "_beat"},   {28'd0, out_beat},  {28'd0, beat});
    @(negedge CLK);
  endtask

  task automatic check_idle(input string tag);
    #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    RSTN      = 1'b0;
    in_valid  = 1'b0;
    in_values = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_valid",  {31'd0, out_valid},  32'd0);
    check("rst_ready",  {31'd0, in_ready},   32'd0);
    check("rst_busy",   {31'd0, busy},       32'd0);
    check("rst_last",   {31'd0, out_last},   32'd0);
    check("rst_mask",   {28'd0, out_mask},   32'd0);
    check("rst_places", {20'd0, out_places}, 32'd0);
    check("rst_beat",   {28'd0, out_beat},   32'd0);
    RSTN = 1'b1;
    check_idle("post_rst");

    // Mixed group
    send_group({8'hA5, 8'h80, 8'h01, 8'h00});
    check_beat("mix0", 4'b1110, pl(7, 7, 0, 0), 1'b0, 4'd0);
    check_beat("mix1", 4'b1000, pl(5, 0, 0, 0), 1'b0, 4'd1);
    check_beat("mix2", 4'b1000, pl(2, 0, 0, 0), 1'b0, 4'd2);
    check_beat("mix3", 4'b1000, pl(0, 0, 0, 0), 1'b1, 4'd3);
    check_idle("mix_end");

    // All-zero group
    send_group(32'h0);
    check_beat("zero0", 4'b0000, pl(0, 0, 0, 0), 1'b1, 4'd0);
    check_idle("zero_end");

    // All ones: eight beats on every lane
    send_group(32'hFFFF_FFFF);
    for (int b = 0; b < 8; b++) begin
      place_t p;
      p = place_t'(7 - b);
      check_beat($sformatf("ff%0d", b), 4'b1111, pl(p, p, p, p), (b == 7), 4'(b));
    end
    check_idle("ff_end");

    // Backpressure at beat1
    send_group({8'hA5, 24'h0});
    check_beat("bp0", 4'b1000, pl(7, 0, 0, 0), 1'b0, 4'd0);
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) check_beat($sformatf("bp_hold%0d", s), 4'b1000, pl(5, 0, 0, 0), 1'b0, 4'd1);
    out_ready = 1'b1;
    check_beat("bp1", 4'b1000, pl(5, 0, 0, 0), 1'b0, 4'd1);
    check_beat("bp2", 4'b1000, pl(2, 0, 0, 0), 1'b0, 4'd2);
    check_beat("bp3", 4'b1000, pl(0, 0, 0, 0), 1'b1, 4'd3);
    check_idle("bp_end");

    // Back-to-back: B accepted on A's last beat
    send_group(32'h0303_0303);
    check_beat("b2b_a0", 4'b1111, pl(1, 1, 1, 1), 1'b0, 4'd0);
    in_valid  = 1'b1;
    in_values = 32'h4040_4040;
    #1;
    check("b2b_ready_on_last", {31'd0, in_ready}, 32'd1);
    check_beat("b2b_a1", 4'b1111, pl(0, 0, 0, 0), 1'b1, 4'd1);
    in_valid  = 1'b0;
    in_values = 32'h1234_5678;
    check_beat("b2b_b0", 4'b1111, pl(6, 6, 6, 6), 1'b1, 4'd0);
    check_idle("b2b_end");

    // Reset in the middle of a group
    send_group(32'hFFFF_FFFF);
    check_beat("rm0", 4'b1111, pl(7, 7, 7, 7), 1'b0, 4'd0);
    check_beat("rm1", 4'b1111, pl(6, 6, 6, 6), 1'b0, 4'd1);
    RSTN = 1'b0;
    #1;
    check("rm_valid", {31'd0, out_valid}, 32'd0);
    check("rm_ready", {31'd0, in_ready},  32'd0);
    check("rm_busy",  {31'd0, busy},      32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    check_idle("rm_release");
    check("rm_beat_clr", {28'd0, out_beat}, 32'd0);
    send_group(32'h0101_0101);
    check_beat("rm_new0", 4'b1111, pl(0, 0, 0, 0), 1'b1, 4'd0);
    check_idle("rm_new_end");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
